lcd_frame_read_master: RTL and testbench
========================================

LCD_FRAME_READ_MASTER -- requirements
Module: lcd_frame_read_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 64, meaning read-data buffer depth in 64-bit words (power of 2, 8..256).
REQ-002 SHALL have parameter MAX_PENDING, default 8, meaning the maximum number of reads issued but not yet returned (1..FIFO_DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle pulse that begins a frame transfer.
REQ-006 SHALL have port base_address, input, 23, the first 64-bit word address, sampled on start.
REQ-007 SHALL have port word_count, input, 23, the number of words in the frame, sampled on start.
REQ-008 SHALL have port busy, output, 1, high from the start acceptance until the last word leaves the stream.
REQ-009 SHALL have ports m_address (output, 23), m_read (output, 1), m_byteenable (output, 8), m_waitrequest (input, 1), m_readdata (input, 64) and m_readdatavalid (input, 1), which form an Avalon-MM pipelined read master.
REQ-010 SHALL have ports out_data (output, 64), out_valid (output, 1), out_ready (input, 1), out_sop (output, 1) and out_eop (output, 1), which form the pixel stream.

Function
REQ-011 SHALL implement the states IDLE, RUN and DRAIN.
REQ-012 SHALL, in IDLE, on start with word_count!=0, latch base_address and word_count, clear the counters and enter RUN on the next cycle.
REQ-013 SHALL ignore start when word_count=0, and SHALL ignore start in RUN and DRAIN.
REQ-014 SHALL, in RUN, assert m_read only when issued<word_count, pending<MAX_PENDING and pending+fifo_used<FIFO_DEPTH.
REQ-015 SHALL hold m_address and m_read stable while m_waitrequest=1.
REQ-016 SHALL count a read as issued only in a cycle with m_read=1 and m_waitrequest=0, and SHALL then increment m_address by 1.
REQ-017 SHALL keep m_byteenable at 8'hFF.
REQ-018 SHALL decrement pending on m_readdatavalid, and SHALL leave pending unchanged when an issue and a return occur in the same cycle.
REQ-019 SHALL write m_readdata into the FIFO on m_readdatavalid, which can never overflow by construction of REQ-014.
REQ-020 SHALL go from RUN to DRAIN in the cycle after the final issue.
REQ-021 SHALL go from DRAIN to IDLE when pending=0, the FIFO is empty and the final word has been accepted.
REQ-022 SHALL have out_valid=!fifo_empty, with out_data being the FIFO head (show-ahead), and SHALL pop the FIFO when out_valid&out_ready.
REQ-023 SHALL assert out_sop with the first word of the frame and out_eop with word number word_count; for word_count=1 both SHALL be asserted together.
REQ-024 SHALL allow a simultaneous FIFO push and pop, leaving fifo_used unchanged.
REQ-025 SHALL wrap m_address modulo 2^23 without error.
REQ-026 SHALL have a latency of 1 cycle from start to the first m_read, and of 1 cycle from an m_readdatavalid into an empty FIFO to out_valid.
REQ-027 SHALL have busy=(state!=IDLE).

Reset
REQ-028 SHALL, on reset_n=0, immediately force state=IDLE, m_read=0, m_address=0, out_valid=0, out_sop=0, out_eop=0, busy=0, pending=0 and the FIFO empty.
REQ-029 SHALL discard in-flight reads on reset mid-frame, and SHALL drop any m_readdatavalid arriving after reset deasserts while pending=0.

Configuration
REQ-030 SHALL, with LCD_FRAME_READ_MASTER_UNDERFLOW_CNT_EN defined, add the output underflow_count (16 bits), which increments, saturating at 16'hFFFF, on each cycle with busy=1, out_ready=1 and out_valid=0, and which clears on accepted start and on reset.
REQ-031 SHALL, without LCD_FRAME_READ_MASTER_UNDERFLOW_CNT_EN, omit the underflow_count port and its logic, with all other behaviour identical.

Verification
REQ-032 SHALL verify that start with base_address=0x000100, word_count=4, zero-wait memory and out_ready=1 gives addresses 0x100..0x103, four words in order, sop on the first, eop on the fourth, and busy low after the last.
REQ-033 SHALL verify that with m_waitrequest=1 for 5 cycles on the first read, m_address=0x100 and m_read=1 are held all 5 cycles and exactly one issue is counted.
REQ-034 SHALL verify that with read latency 20, word_count=32 and MAX_PENDING=8, pending never exceeds 8 and all 32 words arrive.
REQ-035 SHALL verify that with out_ready=0, word_count=100 and FIFO_DEPTH=64, issues stop at pending+fifo_used=64 with no overflow, and that raising out_ready completes all 100 words.
REQ-036 SHALL verify that with base_address=0x7FFFFE and word_count=4, addresses go 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001.
REQ-037 SHALL verify that reset asserted mid-frame with 3 reads pending, followed by 2 late m_readdatavalid pulses, leaves state IDLE, out_valid=0, and a subsequent start with word_count=2 delivering exactly 2 correct words.

Source files
------------

// File: rtl/lcd_frame_read_master.sv
// Avalon-MM pipelined read master that streams one frame of 64-bit words into a pixel stream.
// Optional LCD_FRAME_READ_MASTER_UNDERFLOW_CNT_EN adds a saturating stream-underflow counter.
module lcd_frame_read_master #(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned MAX_PENDING = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [22:0] base_address,
  input  logic [22:0] word_count,
  output logic        busy,
  output logic [22:0] m_address,
  output logic        m_read,
  output logic [7:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [63:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop
`ifdef LCD_FRAME_READ_MASTER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  // Wide enough to hold pending + fifo_used without overflow.
  localparam int unsigned CntW  = AddrW + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e            state_q;
  logic [22:0]       addr_q;
  logic [22:0]       count_q;
  logic [22:0]       issued_q;
  logic [22:0]       popped_q;
  logic [CntW-1:0]   pending_q;
  logic [CntW-1:0]   used_q;
  logic [AddrW-1:0]  wr_ptr_q;
  logic [AddrW-1:0]  rd_ptr_q;
  logic [63:0]       mem_q [FIFO_DEPTH];

  logic            start_ok;
  logic            issue;
  logic            push;
  logic            pop;
  logic            pend_ok;
  logic            room_ok;
  logic [CntW-1:0] inflight;

  always_comb begin
    start_ok = (state_q == StIdle) && start && (word_count != '0);
    inflight = pending_q + used_q;
    pend_ok  = pending_q < CntW'(MAX_PENDING);
    // Reserving FIFO space for every outstanding read makes overflow impossible.
    room_ok  = inflight < CntW'(FIFO_DEPTH);
    m_read   = (state_q == StRun) && (issued_q < count_q) && pend_ok && room_ok;
    issue    = m_read && !m_waitrequest;
    // Returns with nothing outstanding are stale reads from before a reset.
    push     = m_readdatavalid && (pending_q != '0);
    out_valid = (used_q != '0);
    pop      = out_valid && out_ready;
    out_data = mem_q[rd_ptr_q];
    out_sop  = out_valid && (popped_q == '0);
    out_eop  = out_valid && (popped_q == (count_q - 23'd1));
    busy     = (state_q != StIdle);
    m_address    = addr_q;
    m_byteenable = 8'hFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      count_q   <= '0;
      issued_q  <= '0;
      popped_q  <= '0;
      pending_q <= '0;
      used_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_q  <= StRun;
            addr_q   <= base_address;
            count_q  <= word_count;
            issued_q <= '0;
            popped_q <= '0;
          end
        end
        StRun: begin
          if (issue && ((issued_q + 23'd1) == count_q)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if ((pending_q == '0) && (used_q == '0) && (popped_q == count_q)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      if (issue) begin
        addr_q   <= addr_q + 23'd1;
        issued_q <= issued_q + 23'd1;
      end

      if (issue && !push) begin
        pending_q <= pending_q + CntW'(1);
      end else if (!issue && push) begin
        pending_q <= pending_q - CntW'(1);
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AddrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AddrW'(1);
        popped_q <= popped_q + 23'd1;
      end

      if (push && !pop) begin
        used_q <= used_q + CntW'(1);
      end else if (!push && pop) begin
        used_q <= used_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= m_readdata;
    end
  end

`ifdef LCD_FRAME_READ_MASTER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underflow_q <= '0;
    end else if (start_ok) begin
      underflow_q <= '0;
    end else if (busy && out_ready && !out_valid && (underflow_q != 16'hFFFF)) begin
      underflow_q <= underflow_q + 16'd1;
    end
  end

  assign underflow_count = underflow_q;
`endif

endmodule

// File: tb/tb_lcd_frame_read_master.sv
// Directed bench: bench-side memory model plus a frame-level stream model checked every cycle.
module tb_lcd_frame_read_master;

  localparam int FD = 64;
  localparam int MP = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [22:0] base_address = '0;
  logic [22:0] word_count = '0;
  logic        busy;
  logic [22:0] m_address;
  logic        m_read;
  logic [7:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [63:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sop;
  logic        out_eop;
`ifdef LCD_FRAME_READ_MASTER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
`endif

  lcd_frame_read_master #(
    .FIFO_DEPTH (FD),
    .MAX_PENDING(MP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .base_address   (base_address),
    .word_count     (word_count),
    .busy           (busy),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_byteenable   (m_byteenable),
    .m_waitrequest  (m_waitrequest),
    .m_readdata     (m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sop        (out_sop),
    .out_eop        (out_eop)
`ifdef LCD_FRAME_READ_MASTER_UNDERFLOW_CNT_EN
    ,
    .underflow_count(underflow_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Memory model: in-order returns, each due a fixed latency after acceptance.
  logic [22:0] mq_addr[$];
  int          mq_due[$];
  int          cyc = 0;
  int          lat = 1;
  int          wait_left = 0;
  bit          ready_en = 1'b1;

  // Frame model.
  logic [22:0] exp_base = '0;
  int          exp_wc = 0;
  int          issued = 0;
  int          returned = 0;
  int          popped = 0;
  int          max_pend = 0;
  int          hold_cnt = 0;
  bit          prev_wait = 1'b0;
  logic [22:0] prev_addr = '0;
  bit          first_cyc = 1'b0;
  logic [22:0] addr_log[$];

  bit          req_start = 1'b0;
  logic [22:0] req_base = '0;
  logic [22:0] req_wc = '0;

  function automatic logic [63:0] data_of(input logic [22:0] a);
    return {a ^ 23'h555555, 18'h2A5A5, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int          pend;
    int          idx;
    logic [22:0] ea;
    logic [22:0] ra;
    @(negedge clk);
    cyc++;
    pend = issued - returned;
    if (pend > max_pend) max_pend = pend;
    check("out_valid", out_valid, (returned - popped) > 0);
    check("pending_le_max", pend <= MP, 1);
    check("inflight_le_depth", (issued - popped) <= FD, 1);
    if (first_cyc) begin
      check("first_read_latency", m_read, 1);
      check("busy_after_start", busy, 1);
      first_cyc = 1'b0;
    end
    if (out_valid && popped < exp_wc) begin
      idx = popped;
      ea  = exp_base + 23'(idx);
      check("out_data", out_data, data_of(ea));
      check("out_sop", out_sop, idx == 0);
      check("out_eop", out_eop, idx == exp_wc - 1);
    end
    if (prev_wait) begin
      check("hold_read", m_read, 1);
      check("hold_addr", m_address, prev_addr);
    end
    if (m_read) begin
      ea = exp_base + 23'(issued);
      check("m_byteenable", m_byteenable, 8'hFF);
      check("m_address", m_address, ea);
    end
    // Drive this cycle's inputs.
    start        = req_start;
    base_address = req_base;
    word_count   = req_wc;
    req_start    = 1'b0;
    out_ready    = ready_en;
    m_waitrequest = 1'b0;
    if (m_read && wait_left > 0) begin
      m_waitrequest = 1'b1;
      wait_left--;
    end
    if (m_read && m_waitrequest && m_address == 23'h000100) hold_cnt++;
    prev_wait = m_read && m_waitrequest;
    prev_addr = m_address;
    if (m_read && !m_waitrequest) begin
      mq_addr.push_back(m_address);
      mq_due.push_back(cyc + lat);
      addr_log.push_back(m_address);
      issued++;
    end
    m_readdatavalid = 1'b0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      ra = mq_addr.pop_front();
      void'(mq_due.pop_front());
      m_readdatavalid = 1'b1;
      m_readdata = data_of(ra);
      returned++;
    end
    if (out_valid && out_ready) popped++;
  endtask

  task automatic start_frame(input logic [22:0] b, input logic [22:0] n);
    exp_base  = b;
    exp_wc    = int'(n);
    issued    = 0;
    returned  = 0;
    popped    = 0;
    prev_wait = 1'b0;
    addr_log.delete();
    req_start = 1'b1;
    req_base  = b;
    req_wc    = n;
    step();
    first_cyc = 1'b1;
    step();
  endtask

  task automatic finish_frame();
    int guard;
    guard = 0;
    while (popped < exp_wc && guard < 6000) begin
      step();
      guard++;
    end
    check("frame_complete", popped, exp_wc);
    guard = 0;
    while (busy && guard < 8) begin
      step();
      guard++;
    end
    check("busy_low_after_frame", busy, 0);
    check("issued_total", issued, exp_wc);
    step();
    step();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_m_read", m_read, 0);
    check("rst_m_address", m_address, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sop", out_sop, 0);
    check("rst_out_eop", out_eop, 0);
    reset_n = 1'b1;

    // Basic four-word frame, zero-wait memory.
    lat = 1;
    ready_en = 1'b1;
    start_frame(23'h000100, 23'd4);
    finish_frame();
    check("addr0", addr_log.size() > 0 ? addr_log[0] : 23'h7FFFFF, 23'h000100);
    check("addr1", addr_log.size() > 1 ? addr_log[1] : 23'h7FFFFF, 23'h000101);
    check("addr2", addr_log.size() > 2 ? addr_log[2] : 23'h7FFFFF, 23'h000102);
    check("addr3", addr_log.size() > 3 ? addr_log[3] : 23'h7FFFFF, 23'h000103);

    // Five waitrequest cycles on the first read.
    hold_cnt = 0;
    wait_left = 5;
    start_frame(23'h000100, 23'd4);
    finish_frame();
    check("wait_hold_cycles", hold_cnt, 5);
    check("wait_first_issue_addr", addr_log.size() > 1 ? addr_log[1] : 23'h7FFFFF, 23'h000101);

    // Zero-length start is ignored.
    req_start = 1'b1;
    req_base  = 23'h000300;
    req_wc    = 23'd0;
    step();
    step();
    step();
    check("zero_wc_busy", busy, 0);
    check("zero_wc_m_read", m_read, 0);

    // Latency 20: outstanding reads capped; mid-frame start ignored.
    lat = 20;
    max_pend = 0;
    start_frame(23'h001000, 23'd32);
    repeat (10) step();
    req_start = 1'b1;
    req_base  = 23'h000555;
    req_wc    = 23'd7;
    finish_frame();
    check("max_pending", max_pend, MP);

    // Stalled sink: issuing must stop with the FIFO fully reserved.
    lat = 2;
    ready_en = 1'b0;
    start_frame(23'h002000, 23'd100);
    repeat (300) step();
    check("stall_issued", issued, 64);
    check("stall_returned", returned, 64);
    ready_en = 1'b1;
    finish_frame();

    // Address wrap at 2^23.
    lat = 1;
    start_frame(23'h7FFFFE, 23'd4);
    finish_frame();
    check("wrap0", addr_log.size() > 0 ? addr_log[0] : 23'h1234, 23'h7FFFFE);
    check("wrap1", addr_log.size() > 1 ? addr_log[1] : 23'h1234, 23'h7FFFFF);
    check("wrap2", addr_log.size() > 2 ? addr_log[2] : 23'h1234, 23'h000000);
    check("wrap3", addr_log.size() > 3 ? addr_log[3] : 23'h1234, 23'h000001);

    // Single-word frame: sop and eop together.
    start_frame(23'h000003, 23'd1);
    finish_frame();

    // Reset mid-frame with three reads outstanding, then stale returns.
    lat = 20;
    start_frame(23'h000200, 23'd16);
    for (int g = 0; g < 50 && issued < 3; g++) step();
    @(posedge clk);
    #2;
    check("pre_reset_pending", issued - returned, 3);
    reset_n = 1'b0;
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;
    #1;
    check("mid_rst_m_read", m_read, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_m_address", m_address, 0);
    mq_addr.delete();
    mq_due.delete();
    issued = 0;
    returned = 0;
    popped = 0;
    exp_wc = 0;
    prev_wait = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      m_readdatavalid = 1'b1;
      m_readdata = 64'hDEAD_BEEF_0000_0000 | 64'(k);
    end
    @(negedge clk);
    m_readdatavalid = 1'b0;
    @(negedge clk);
    check("late_rdv_busy", busy, 0);
    check("late_rdv_out_valid", out_valid, 0);
    lat = 1;
    start_frame(23'h000040, 23'd2);
    finish_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
